// File: rtl/simple_cnn_param.sv
// Single-layer CNN classifier: KxK valid conv, saturating ReLU, FC to NCLASS scores, argmax; one MAC/cycle.
// Optional per-class FC bias input enabled by defining SCNN_BIAS_EN.
module simple_cnn_param #(
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5,
    parameter int PIX_W  = 8,
    parameter int K      = 3,
    parameter int W_W    = 8,
    parameter int NCLASS = 4,
    parameter int ACC_W  = 24
) (
    input  logic                                               CLK,
    input  logic                                               RST,
    input  logic                                               START,
    input  logic [IMG_W*IMG_H*PIX_W-1:0]                       IMGIN,
    input  logic [K*K*W_W-1:0]                                 KERNIN,
    input  logic [NCLASS*(IMG_W-K+1)*(IMG_H-K+1)*W_W-1:0]      WGTIN,
`ifdef SCNN_BIAS_EN
    input  logic [NCLASS*W_W-1:0]                              BIASIN,
`endif
    output logic                                               BUSY,
    output logic                                               DONE,
    output logic [$clog2(NCLASS)-1:0]                          OUT
);
    localparam int OW  = IMG_W - K + 1;
    localparam int OH  = IMG_H - K + 1;
    localparam int NF  = OW * OH;
    localparam int CW  = $clog2(NCLASS);
    localparam int CTW = 16;
    localparam logic [CTW-1:0] K_LAST  = CTW'(K - 1);
    localparam logic [CTW-1:0] OX_LAST = CTW'(OW - 1);
    localparam logic [CTW-1:0] OY_LAST = CTW'(OH - 1);
    localparam logic [CTW-1:0] F_LAST  = CTW'(NF - 1);
    localparam logic [CTW-1:0] C_LAST  = CTW'(NCLASS - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_FC, S_FIN} state_t;
    state_t state, state_next;

    logic [IMG_W*IMG_H*PIX_W-1:0] img_r;
    logic [K*K*W_W-1:0]           ker_r;
    logic [NCLASS*NF*W_W-1:0]     wgt_r;
    logic [NF*PIX_W-1:0]          feat_r;
    logic [CTW-1:0]               kx, ky, ox, oy, f, c;
    logic signed [ACC_W-1:0]      acc, op_a, op_b, sum, best, acc_init;
    logic [CW-1:0]                best_idx;
    logic [31:0]                  pix_sel, tap_sel, feat_sel, wgt_sel;
    logic [PIX_W-1:0]             feat_val;
    logic                         tap_last, conv_last, f_last, fc_last;
`ifdef SCNN_BIAS_EN
    logic [NCLASS*W_W-1:0]        bias_r;
    logic [31:0]                  bias_sel;
`endif

    always_comb begin
        tap_last  = (kx == K_LAST) && (ky == K_LAST);
        conv_last = tap_last && (ox == OX_LAST) && (oy == OY_LAST);
        f_last    = (f == F_LAST);
        fc_last   = f_last && (c == C_LAST);
        pix_sel   = (32'(oy) + 32'(ky)) * IMG_W + 32'(ox) + 32'(kx);
        tap_sel   = 32'(ky) * K + 32'(kx);
        feat_sel  = (state == S_FC) ? 32'(f) : 32'(oy) * OW + 32'(ox);
        wgt_sel   = 32'(c) * NF + 32'(f);
        op_a      = '0;
        op_b      = '0;
        if (state == S_CONV) begin
            op_a = ACC_W'(img_r[pix_sel*PIX_W +: PIX_W]);
            op_b = ACC_W'($signed(ker_r[tap_sel*W_W +: W_W]));
        end else if (state == S_FC) begin
            op_a = ACC_W'(feat_r[feat_sel*PIX_W +: PIX_W]);
            op_b = ACC_W'($signed(wgt_r[wgt_sel*W_W +: W_W]));
        end
        sum = acc + op_a * op_b;
        if (sum[ACC_W-1])
            feat_val = '0;
        else if (sum > PIX_MAX)
            feat_val = PIX_MAX[PIX_W-1:0];
        else
            feat_val = sum[PIX_W-1:0];
        // Seed for the next FC accumulation: class 0 when leaving CONV, class c+1 inside FC.
`ifdef SCNN_BIAS_EN
        bias_sel = (state == S_FC) ? 32'(c) + 32'd1 : 32'd0;
        acc_init = (bias_sel < NCLASS) ? ACC_W'($signed(bias_r[bias_sel*W_W +: W_W])) : '0;
`else
        acc_init = '0;
`endif
    end

    always_comb begin
        state_next = state;
        BUSY       = (state != S_IDLE);
        case (state)
            S_IDLE:  if (START) state_next = S_CONV;
            S_CONV:  if (conv_last) state_next = S_FC;
            S_FC:    if (fc_last) state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge CLK) begin
        if (state == S_IDLE && START) begin
            img_r <= IMGIN;
            ker_r <= KERNIN;
            wgt_r <= WGTIN;
`ifdef SCNN_BIAS_EN
            bias_r <= BIASIN;
`endif
        end
        if (state == S_CONV && tap_last)
            feat_r[feat_sel*PIX_W +: PIX_W] <= feat_val;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc      <= '0;
            kx       <= '0;
            ky       <= '0;
            ox       <= '0;
            oy       <= '0;
            f        <= '0;
            c        <= '0;
            best     <= '0;
            best_idx <= '0;
            DONE     <= 1'b0;
            OUT      <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        acc <= '0;
                        kx  <= '0;
                        ky  <= '0;
                        ox  <= '0;
                        oy  <= '0;
                        f   <= '0;
                        c   <= '0;
                    end
                end
                S_CONV: begin
                    if (tap_last) acc <= conv_last ? acc_init : '0;
                    else          acc <= sum;
                    if (kx != K_LAST) begin
                        kx <= kx + 1'b1;
                    end else begin
                        kx <= '0;
                        if (ky != K_LAST) begin
                            ky <= ky + 1'b1;
                        end else begin
                            ky <= '0;
                            if (ox != OX_LAST) begin
                                ox <= ox + 1'b1;
                            end else begin
                                ox <= '0;
                                oy <= oy + 1'b1;
                            end
                        end
                    end
                end
                S_FC: begin
                    if (f_last) begin
                        acc <= acc_init;
                        if (c == '0 || sum > best) begin
                            best     <= sum;
                            best_idx <= CW'(c);
                        end
                        f <= '0;
                        c <= c + 1'b1;
                    end else begin
                        acc <= sum;
                        f   <= f + 1'b1;
                    end
                end
                S_FIN: begin
                    DONE <= 1'b1;
                    OUT  <= best_idx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_simple_cnn_param.sv
// Randomised self-checking bench for simple_cnn_param against a plain-arithmetic classifier model.
// Define SCNN_BIAS_EN for both files to exercise the bias input.
module tb_simple_cnn_param;
    localparam int IMG_W  = 5;
    localparam int IMG_H  = 5;
    localparam int PIX_W  = 8;
    localparam int K      = 3;
    localparam int W_W    = 8;
    localparam int NCLASS = 4;
    localparam int ACC_W  = 24;
    localparam int OW     = IMG_W - K + 1;
    localparam int OH     = IMG_H - K + 1;
    localparam int NF     = OW * OH;
    localparam int CW     = $clog2(NCLASS);
    localparam int LAT    = NF * K * K + NCLASS * NF + 1;

    logic CLK = 1'b0;
    logic RST, START;
    logic [IMG_W*IMG_H*PIX_W-1:0] IMGIN;
    logic [K*K*W_W-1:0]           KERNIN;
    logic [NCLASS*NF*W_W-1:0]     WGTIN;
`ifdef SCNN_BIAS_EN
    logic [NCLASS*W_W-1:0]        BIASIN;
`endif
    logic BUSY, DONE;
    logic [CW-1:0] OUT;

    int checks = 0;
    int errors = 0;
    int pix  [IMG_W*IMG_H];
    int tap  [K*K];
    int wgt  [NCLASS*NF];
    int bias [NCLASS];

    simple_cnn_param #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .K(K),
        .W_W(W_W), .NCLASS(NCLASS), .ACC_W(ACC_W)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .IMGIN(IMGIN), .KERNIN(KERNIN), .WGTIN(WGTIN),
`ifdef SCNN_BIAS_EN
        .BIASIN(BIASIN),
`endif
        .BUSY(BUSY), .DONE(DONE), .OUT(OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_class();
        int feat [NF];
        int s, best, best_c;
        best = 0;
        best_c = 0;
        for (int oy = 0; oy < OH; oy++)
            for (int ox = 0; ox < OW; ox++) begin
                s = 0;
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        s += pix[(oy + ky) * IMG_W + ox + kx] * tap[ky * K + kx];
                feat[oy * OW + ox] = (s < 0) ? 0 : (s > 255) ? 255 : s;
            end
        for (int cl = 0; cl < NCLASS; cl++) begin
            s = bias[cl];
            for (int fi = 0; fi < NF; fi++) s += feat[fi] * wgt[cl * NF + fi];
            if (cl == 0 || s > best) begin
                best = s;
                best_c = cl;
            end
        end
        return best_c;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < IMG_W*IMG_H; i++) IMGIN[i*PIX_W +: PIX_W] = PIX_W'(pix[i]);
        for (int i = 0; i < K*K; i++)         KERNIN[i*W_W +: W_W]    = W_W'(tap[i]);
        for (int i = 0; i < NCLASS*NF; i++)   WGTIN[i*W_W +: W_W]     = W_W'(wgt[i]);
`ifdef SCNN_BIAS_EN
        for (int i = 0; i < NCLASS; i++)      BIASIN[i*W_W +: W_W]    = W_W'(bias[i]);
`endif
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < IMG_W*IMG_H; i++) IMGIN[i*PIX_W +: PIX_W] = PIX_W'($urandom);
        for (int i = 0; i < K*K; i++)         KERNIN[i*W_W +: W_W]    = W_W'($urandom);
        for (int i = 0; i < NCLASS*NF; i++)   WGTIN[i*W_W +: W_W]     = W_W'($urandom);
`ifdef SCNN_BIAS_EN
        for (int i = 0; i < NCLASS; i++)      BIASIN[i*W_W +: W_W]    = W_W'($urandom);
`endif
    endtask

    task automatic randomize_data(input bit small_taps);
        for (int i = 0; i < IMG_W*IMG_H; i++) pix[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < K*K; i++)
            tap[i] = small_taps ? int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < NCLASS*NF; i++)   wgt[i] = int'($urandom_range(0, 255)) - 128;
`ifdef SCNN_BIAS_EN
        for (int i = 0; i < NCLASS; i++)      bias[i] = int'($urandom_range(0, 255)) - 128;
`endif
    endtask

    // One run from the current arrays; optionally re-pulses START with junk data mid-run.
    task automatic run_one(input string tag, input bit poke_start);
        int exp, lat;
        bit busy_ok;
        exp = model_class();
        drive_inputs();
        START = 1'b1;
        @(posedge CLK); @(negedge CLK);
        START = 1'b0;
        scramble_inputs();
        check({tag, "_busy_start"}, int'(BUSY), 1);
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= LAT + 20; k++) begin
            START = (poke_start && k == 50);
            @(posedge CLK); @(negedge CLK);
            if (DONE) begin
                lat = k;
                break;
            end
            if (!BUSY) busy_ok = 1'b0;
        end
        START = 1'b0;
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_busy_run"}, int'(busy_ok), 1);
        check({tag, "_out"}, int'(OUT), exp);
        @(posedge CLK); @(negedge CLK);
        check({tag, "_done_pulse"}, int'(DONE), 0);
        check({tag, "_out_hold"}, int'(OUT), exp);
    endtask

    initial begin
        int ndone, first_k, second_k, exp;
        RST = 1'b1;
        START = 1'b0;
        for (int i = 0; i < NCLASS; i++) bias[i] = 0;
        scramble_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_done", int'(DONE), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_out", int'(OUT), 0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        check("idle_busy", int'(BUSY), 0);
        check("idle_done", int'(DONE), 0);

        for (int i = 0; i < IMG_W*IMG_H; i++) pix[i] = 1;
        for (int i = 0; i < K*K; i++) tap[i] = 1;
        for (int i = 0; i < NCLASS*NF; i++) wgt[i] = (i / NF == 2) ? 1 : 0;
        run_one("allones", 1'b0);
        check("allones_class", int'(OUT), 2);

        for (int i = 0; i < IMG_W*IMG_H; i++) pix[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < K*K; i++) tap[i] = -1;
        for (int i = 0; i < NCLASS*NF; i++) wgt[i] = int'($urandom_range(0, 255)) - 128;
        run_one("negtaps", 1'b0);
        check("negtaps_class", int'(OUT), 0);

        for (int i = 0; i < IMG_W*IMG_H; i++) pix[i] = 255;
        for (int i = 0; i < K*K; i++) tap[i] = 1;
        for (int i = 0; i < NCLASS*NF; i++) wgt[i] = (i / NF == 3) ? 1 : 0;
        run_one("saturate", 1'b0);
        check("saturate_class", int'(OUT), 3);

        // Abort a run at edge 40; nothing may complete and OUT returns to 0.
        randomize_data(1'b1);
        drive_inputs();
        START = 1'b1;
        @(posedge CLK); @(negedge CLK);
        START = 1'b0;
        repeat (39) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_out", int'(OUT), 0);
        ndone = 0;
        for (int k = 0; k < LAT + 40; k++) begin
            @(negedge CLK);
            if (DONE) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        randomize_data(1'b1);
        run_one("after_rst", 1'b0);

        // START held for 200 cycles: exactly two back-to-back runs.
        randomize_data(1'b1);
        exp = model_class();
        drive_inputs();
        START = 1'b1;
        @(posedge CLK); @(negedge CLK);
        ndone = 0;
        first_k = -1;
        second_k = -1;
        for (int k = 1; k <= 400; k++) begin
            START = (k < 200);
            @(posedge CLK); @(negedge CLK);
            if (DONE) begin
                ndone++;
                if (first_k < 0) first_k = k;
                else if (second_k < 0) second_k = k;
                check("held_out", int'(OUT), exp);
            end
        end
        START = 1'b0;
        check("held_ndone", ndone, 2);
        check("held_first", first_k, LAT);
        check("held_second", second_k, 2 * LAT + 1);

`ifdef SCNN_BIAS_EN
        for (int i = 0; i < IMG_W*IMG_H; i++) pix[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < K*K; i++) tap[i] = int'($urandom_range(0, 6)) - 3;
        for (int i = 0; i < NCLASS*NF; i++) wgt[i] = 0;
        bias[0] = 0;
        bias[1] = 5;
        bias[2] = -3;
        bias[3] = 5;
        run_one("bias", 1'b0);
        check("bias_class", int'(OUT), 1);
`endif

        for (int r = 0; r < 8; r++) begin
            randomize_data(r % 3 != 0);
            run_one($sformatf("rand%0d", r), r % 2 == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
